// File: rtl/series_pkg.sv
// Shared types and helpers for the fixed-point Taylor-series engine.
// Holds mode and state encodings plus the common saturation function.
package series_pkg;

  localparam logic [1:0] MODE_EXP = 2'd0;
  localparam logic [1:0] MODE_SIN = 2'd1;
  localparam logic [1:0] MODE_COS = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SQR,
    S_INIT,
    S_MUL_X,
    S_MUL_C,
    S_ACC,
    S_DONE
  } state_e;

  typedef struct packed {
    logic        ovf;
    logic [63:0] val;
  } sat_t;

  // Clamp a wide signed value into a w-bit two's complement range.
  function automatic sat_t sat_fn(
    input logic signed [63:0] v,
    input int unsigned        w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sat_t s;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    s.ovf = 1'b0;
    s.val = v;
    if (v > hi) begin
      s.ovf = 1'b1;
      s.val = hi;
    end else if (v < lo) begin
      s.ovf = 1'b1;
      s.val = lo;
    end
    return s;
  endfunction

endpackage

// File: rtl/series_engine_coeff.sv
// Coefficient table for the series engine, indexed by {mode, n}.
// Every entry is a constant resolved at elaboration time.
module series_coeff_rom
  import series_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12,
  parameter int TERMS = 8
) (
  input  logic [1:0]             mode_i,
  input  logic [$clog2(TERMS):0] n_i,
  output logic [WIDTH-1:0]       coef_o
);

  localparam int NW    = $clog2(TERMS) + 1;
  localparam int NE    = 2 ** NW;
  localparam int DEPTH = 4 * NE;

  // Round-half-up of 2^FRAC/d, negated for the alternating series.
  function automatic longint coef_calc(input int m, input int n);
    longint one;
    longint d;
    longint q;
    bit     neg;
    one = longint'(1) << FRAC;
    if (n == 0) return 0;
    if (m == int'(MODE_SIN)) begin
      d   = longint'(2 * n) * longint'(2 * n + 1);
      neg = 1'b1;
    end else if (m == int'(MODE_COS)) begin
      d   = longint'(2 * n - 1) * longint'(2 * n);
      neg = 1'b1;
    end else begin
      d   = longint'(n);
      neg = 1'b0;
    end
    q = (2 * one + d) / (2 * d);
    return neg ? -q : q;
  endfunction

  logic [WIDTH-1:0] tbl [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_tbl
    localparam logic [WIDTH-1:0] C =
      WIDTH'(coef_calc(i / NE, i % NE));
    assign tbl[i] = C;
  end

  assign coef_o = tbl[{mode_i, n_i}];

endmodule

// File: rtl/series_engine.sv
// Taylor-series evaluator for e^x, sin x and cos x in fixed point.
// One FSM drives a shared multiplier and a saturating accumulator.
module series_engine
  import series_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12,
  parameter int TERMS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] x_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam int NW = $clog2(TERMS) + 1;
  localparam logic [WIDTH-1:0] ONE =
    {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
  localparam logic [NW-1:0] LAST = NW'(TERMS - 1);

  state_e                    state_q;
  logic signed [WIDTH-1:0]   x_q;
  logic signed [WIDTH-1:0]   x2_q;
  logic signed [WIDTH-1:0]   t_q;
  logic signed [WIDTH-1:0]   r_q;
  logic [NW-1:0]             n_q;
  logic [1:0]                mode_q;
  logic                      busy_q;
  logic                      done_q;
  logic [WIDTH-1:0]          result_q;
  logic                      ovf_q;
  logic                      sat_q;

  logic                      trig;
  logic signed [WIDTH-1:0]   coef;
  logic signed [WIDTH-1:0]   mul_a;
  logic signed [WIDTH-1:0]   mul_b;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] prod_sh;
  logic signed [WIDTH:0]     sum;
  sat_t                      mul_s;
  sat_t                      add_s;
  logic [WIDTH-1:0]          mul_v;
  logic [WIDTH-1:0]          add_v;
  logic                      unused_hi;

  assign trig = (mode_q == MODE_SIN) || (mode_q == MODE_COS);

  series_coeff_rom #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC),
    .TERMS (TERMS)
  ) u_rom (
    .mode_i (mode_q),
    .n_i    (n_q),
    .coef_o (coef)
  );

  always_comb begin
    mul_a = t_q;
    mul_b = coef;
    unique case (1'b1)
      (state_q == S_SQR): begin
        mul_a = x_q;
        mul_b = x_q;
      end
      (state_q == S_MUL_X): begin
        mul_a = t_q;
        mul_b = trig ? x2_q : x_q;
      end
      default: begin
        mul_a = t_q;
        mul_b = coef;
      end
    endcase
  end

  assign prod    = mul_a * mul_b;
  assign prod_sh = prod >>> FRAC;
  assign mul_s   = sat_fn(64'(prod_sh), WIDTH);
  assign sum     = {r_q[WIDTH-1], r_q} + {t_q[WIDTH-1], t_q};
  assign add_s   = sat_fn(64'(sum), WIDTH);
  assign mul_v   = mul_s.val[WIDTH-1:0];
  assign add_v   = add_s.val[WIDTH-1:0];

  // Bits above WIDTH are always a sign copy after clamping.
  assign unused_hi = ^{mul_s.val[63:WIDTH], add_s.val[63:WIDTH]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      x2_q     <= '0;
      t_q      <= '0;
      r_q      <= '0;
      n_q      <= '0;
      mode_q   <= MODE_EXP;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      sat_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            x_q     <= x_in;
            mode_q  <= mode;
            ovf_q   <= 1'b0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_LOAD;
          end
        end
        S_LOAD: state_q <= trig ? S_SQR : S_INIT;
        S_SQR: begin
          x2_q    <= mul_v;
          sat_q   <= sat_q | mul_s.ovf;
          state_q <= S_INIT;
        end
        S_INIT: begin
          n_q     <= NW'(1);
          t_q     <= (mode_q == MODE_SIN) ? x_q : ONE;
          r_q     <= (mode_q == MODE_SIN) ? x_q : ONE;
          state_q <= S_MUL_X;
        end
        S_MUL_X: begin
          t_q     <= mul_v;
          sat_q   <= sat_q | mul_s.ovf;
          state_q <= S_MUL_C;
        end
        S_MUL_C: begin
          t_q     <= mul_v;
          sat_q   <= sat_q | mul_s.ovf;
          state_q <= S_ACC;
        end
        S_ACC: begin
          r_q   <= add_v;
          n_q   <= n_q + NW'(1);
          sat_q <= sat_q | add_s.ovf;
          if (n_q == LAST) begin
            result_q <= add_v;
            ovf_q    <= sat_q | add_s.ovf;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            state_q <= S_MUL_X;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

// File: doc/series_engine.md
# series_engine

Parametrised fixed-point Taylor-series evaluator: one controller FSM plus a shared-multiplier datapath computing e^x, sin x or cos x over a configurable number of terms. It generalises the team's single-function series controller: data width, fraction bits, term count and function mode are configurable, arithmetic saturates and overflow is reported. It sits as a leaf compute unit behind a start/done handshake.

## Interface
- WIDTH, 16: data width, signed two's complement, range 8..32
- FRAC, 12: fraction bits, Q(WIDTH-FRAC-1).FRAC, FRAC < WIDTH-2
- TERMS, 8: number of series terms including the constant/first term, range 2..16
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request; sampled only in IDLE
- mode  in  2  0 = exp, 1 = sin, 2 = cos, 3 = treated as exp
- x_in  in  WIDTH  argument, sampled with start
- busy  out  1  high from the cycle after start acceptance through DONE
- done  out  1  one-cycle pulse, result valid
- result  out  WIDTH  last computed value, held until the next accepted start
- ovf  out  1  sticky saturation flag for the current evaluation, cleared on start acceptance

## Operation
- States: IDLE, LOAD, SQR, INIT, MUL_X, MUL_C, ACC, DONE.
- IDLE: start=1 registers x_in and mode, clears ovf, then goes to LOAD. start while not in IDLE is ignored.
- LOAD: goes to SQR for mode 1/2 and to INIT for exp.
- SQR: x2 <= sat(x*x).
- INIT: n <= 1.
  - exp: t = r = 1.0.
  - sin: t = r = x.
  - cos: t = r = 1.0.
- MUL_X: t <= sat(t*opx), where opx = x for exp and x2 for sin/cos.
- MUL_C: t <= sat(t*coef(mode,n)).
  - exp: coef = 1/n.
  - sin: coef = -1/((2n)(2n+1)).
  - cos: coef = -1/((2n-1)(2n)).
  - Coefficients are rounded to nearest at FRAC bits.
- ACC: r <= sat(r+t) and n <= n+1. If n == TERMS-1 go to DONE, else go to MUL_X.
- DONE: result <= r, done=1, then IDLE.
- Multiply: full 2*WIDTH signed product, arithmetic shift right by FRAC (truncate toward −inf), then saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Add: saturating to the same range.
- Any saturation event sets ovf; evaluation continues.
- A single multiplier is shared by SQR, MUL_X and MUL_C.

## Timing
- Reset (any time, including mid-evaluation): state IDLE. busy=0, done=0, result=0, ovf=0; internal registers cleared. No done pulse is produced for an aborted evaluation.
- Cycle 0 is the edge that samples start in IDLE.
  - State is LOAD in cycle 1.
  - exp: done is high in cycle 3*TERMS.
  - sin/cos: done is high in cycle 3*TERMS+1 (SQR inserted).
  - TERMS=8: exp done at cycle 24, sin/cos at cycle 25.
- busy is high from cycle 1 through the DONE cycle inclusive; it is low in the cycle after DONE.
- result and ovf are updated in the DONE cycle and are visible while done=1. They hold until the next accepted start (ovf clears at acceptance; result holds through the next evaluation).
- start high in the DONE cycle is ignored. start is accepted earliest in the following IDLE cycle, giving back-to-back evaluations with a one-cycle IDLE gap.
- The loop counter n is $clog2(TERMS)+1 bits. The terminal compare is exact, so no wrap occurs.

## Structure
- Package series_pkg holds:
  - mode encodings (MODE_EXP, MODE_SIN, MODE_COS);
  - state encoding;
  - the saturation helper function, shared by the multiply and add paths.
- Sub-module series_coeff_rom (parameters WIDTH, FRAC, TERMS):
  - combinational table indexed by {mode, n};
  - contents computed at elaboration;
  - verified standalone against the reals rounded to nearest.
- series_engine contains the FSM, the x/x2/t/r/n registers and the shared multiplier.

## Test plan
All scenarios use WIDTH=16, FRAC=12, TERMS=8.
- exp(0): mode=0, x_in=0x0000 -> done at cycle 24, result=0x1000, ovf=0.
- exp(1): mode=0, x_in=0x1000 -> result=0x2B7E ±4 LSB, ovf=0, busy high for cycles 1..24 exactly.
- sin(0.5) and cos(0): mode=1, x_in=0x0800 -> result=0x07AC ±4 LSB at cycle 25. Then mode=2, x_in=0x0000 -> result=0x1000.
- Overflow: mode=0, x_in=0x2800 (2.5) -> result=0x7FFF, ovf=1. The next start with x_in=0 clears ovf at acceptance.
- Handshake: start held high throughout -> evaluations are accepted only in IDLE, done pulses exactly 1 cycle wide and are spaced 25 cycles apart (exp). A start pulse in mid-evaluation changes nothing.
- Reset mid-operation: assert rst in cycle 10 of exp(1) -> all outputs 0 immediately and no done pulse. A new start after release gives the correct exp(1).
